acc6_ovf_stage: RTL and testbench



---
 rtl/acc6_pkg.sv | 9 +
 rtl/acc_adder6.sv | 24 ++
 rtl/acc6_ovf_stage.sv | 87 ++++++++
 tb/tb_acc6_ovf_stage.sv | 131 +++++++++++++
 4 files changed

// File: rtl/acc6_pkg.sv
// Shared types and constants for the 6-bit signed accumulator stage.
package acc6_pkg;
  localparam int ACC_W = 6;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef logic [ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_CLR} op_e;
endpackage

// File: rtl/acc_adder6.sv
// Combinational ripple-carry adder built from full-adder cells; exposes the
// carry into and out of the MSB so the caller can form signed overflow.
module acc_adder6 #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_msb_in,
  output logic             c_out
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_msb_in = c[WIDTH-1];
  assign c_out    = c[WIDTH];
endmodule

// File: rtl/acc6_ovf_stage.sv
// Registered signed accumulator with valid/ready handshake and overflow flags.
// Define ACC6_SAT_EN to saturate the accumulator on signed overflow.
import acc6_pkg::*;

module acc6_ovf_stage #(
  parameter int WIDTH = ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             ovf_sticky
);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc, b, sum, acc_nxt;
  logic             cin, c_msb_in, c_out, cout_nxt, ovf_nxt, sticky_nxt;
  logic             accept;
  op_e              op;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_acc  = acc;

  always_comb begin
    op = in_clr ? OP_CLR : (in_sub ? OP_SUB : OP_ADD);
    b   = in_data;
    cin = 1'b0;
    if (op == OP_SUB) begin
      b   = ~in_data;
      cin = 1'b1;
    end
  end

  acc_adder6 #(.WIDTH(WIDTH)) u_add (
    .a        (acc),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .c_msb_in (c_msb_in),
    .c_out    (c_out)
  );

  always_comb begin
    acc_nxt    = sum;
    cout_nxt   = c_out;
    ovf_nxt    = c_msb_in ^ c_out;
`ifdef ACC6_SAT_EN
    // On overflow both operands share acc's sign, so acc's MSB picks the rail.
    if (ovf_nxt) acc_nxt = acc[WIDTH-1] ? SMIN : SMAX;
`endif
    sticky_nxt = ovf_sticky | ovf_nxt;
    if (op == OP_CLR) begin
      acc_nxt    = in_data;
      cout_nxt   = 1'b0;
      ovf_nxt    = 1'b0;
      sticky_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_cout   <= 1'b0;
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      acc        <= acc_nxt;
      out_valid  <= 1'b1;
      out_cout   <= cout_nxt;
      out_ovf    <= ovf_nxt;
      ovf_sticky <= sticky_nxt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acc6_ovf_stage.sv
// Directed table-driven bench for acc6_ovf_stage plus handshake/reset sequences.
module tb_acc6_ovf_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sub, in_clr;
  logic [5:0] in_data;
  logic       out_valid, out_ready, out_cout, out_ovf, ovf_sticky;
  logic [5:0] out_acc;

  int errors = 0;
  int checks = 0;

  acc6_ovf_stage #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cout(out_cout), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld, clr, sub;
    logic [5:0] data;
    logic       e_valid;
    logic [5:0] e_acc;
    logic       e_cout, e_ovf, e_sticky;
  } vec_t;

  function automatic logic [5:0] pick(input logic [5:0] wrap_v, input logic [5:0] sat_v);
`ifdef ACC6_SAT_EN
    return sat_v;
`else
    return wrap_v;
`endif
  endfunction

  vec_t vt[$];

  initial begin
    //                vld clr sub data   val acc                     co ov st
    vt.push_back('{1, 1, 0, 6'd10, 1, 6'h0A,               0, 0, 0});
    vt.push_back('{1, 0, 0, 6'd5,  1, 6'h0F,               0, 0, 0});
    vt.push_back('{1, 1, 0, 6'd31, 1, 6'h1F,               0, 0, 0});
    vt.push_back('{1, 0, 0, 6'd1,  1, pick(6'h20, 6'h1F),  0, 1, 1});
    vt.push_back('{1, 0, 0, 6'd0,  1, pick(6'h20, 6'h1F),  0, 0, 1});
    vt.push_back('{1, 1, 0, 6'h20, 1, 6'h20,               0, 0, 0});
    vt.push_back('{1, 0, 1, 6'd1,  1, pick(6'h1F, 6'h20),  1, 1, 1});
    vt.push_back('{1, 1, 0, 6'd0,  1, 6'h00,               0, 0, 0});
    vt.push_back('{1, 0, 0, 6'h3D, 1, 6'h3D,               0, 0, 0});
    vt.push_back('{1, 0, 1, 6'h3D, 1, 6'h00,               1, 0, 0});
    vt.push_back('{1, 0, 1, 6'h20, 1, pick(6'h20, 6'h1F),  0, 1, 1});
    vt.push_back('{1, 1, 0, 6'h3F, 1, 6'h3F,               0, 0, 0});
    vt.push_back('{1, 0, 0, 6'h3F, 1, 6'h3E,               1, 0, 0});
    vt.push_back('{0, 0, 0, 6'h15, 0, 6'h3E,               1, 0, 0});

    rst = 1'b1; in_valid = 0; in_sub = 0; in_clr = 0; in_data = '0; out_ready = 1;
    #1;
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_acc", {2'd0, out_acc}, 8'd0);
    chk("rst_flags", {5'd0, out_cout, out_ovf, ovf_sticky}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      @(negedge clk);
      in_valid = vt[i].vld; in_clr = vt[i].clr; in_sub = vt[i].sub; in_data = vt[i].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {7'd0, out_valid}, {7'd0, vt[i].e_valid});
      chk($sformatf("v%0d_acc", i), {2'd0, out_acc}, {2'd0, vt[i].e_acc});
      chk($sformatf("v%0d_flags", i), {5'd0, out_cout, out_ovf, ovf_sticky},
          {5'd0, vt[i].e_cout, vt[i].e_ovf, vt[i].e_sticky});
    end

    // Backpressure: result held, operand stalls until out_ready rises.
    @(negedge clk);
    in_valid = 1; in_clr = 1; in_sub = 0; in_data = 6'd7; out_ready = 0;
    @(posedge clk); #1;
    chk("bp_load_valid", {7'd0, out_valid}, 8'd1);
    @(negedge clk);
    in_clr = 0; in_data = 6'd2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready%0d", k), {7'd0, in_ready}, 8'd0);
      chk($sformatf("bp_acc%0d", k), {2'd0, out_acc}, 8'd7);
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1; #1;
    chk("bp_ready_up", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    chk("bp_new_acc", {2'd0, out_acc}, 8'd9);
    chk("bp_new_valid", {7'd0, out_valid}, 8'd1);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); #1;
    chk("bp_drain", {7'd0, out_valid}, 8'd0);

    // Reset mid-stream with a pending overflowed result.
    @(negedge clk);
    in_valid = 1; in_clr = 1; in_data = 6'd31;
    @(negedge clk);
    in_clr = 0; in_data = 6'd1;
    @(negedge clk);
    chk("mid_sticky_pre", {7'd0, ovf_sticky}, 8'd1);
    out_ready = 0; in_data = 6'd3;
    rst = 1; #1;
    chk("mid_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_acc", {2'd0, out_acc}, 8'd0);
    chk("mid_sticky", {7'd0, ovf_sticky}, 8'd0);
    @(posedge clk); #1;
    chk("mid_hold_acc", {2'd0, out_acc}, 8'd0);
    @(negedge clk);
    rst = 0; in_valid = 0; out_ready = 1; #1;
    chk("mid_ready", {7'd0, in_ready}, 8'd1);
    @(posedge clk); #1;
    chk("mid_no_accept", {7'd0, out_valid}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
